// File: rtl/dm_access_seq.sv
// dm_access_seq
//   Sequences one MEM-stage load/store at a time onto the data-memory
//   byte-lane controller. A request is accepted in IDLE, checked for
//   alignment, issued for exactly one ACCESS cycle, and (for loads) waits
//   RD_LAT cycles for read data before a one-cycle response pulse.
//   Misaligned requests skip the memory and answer with an error pulse.
//
// Parameters
//   RD_LAT    : data-memory read latency after the access cycle (1..3)
//
// Ports
//   clk, rstn                  : clock, asynchronous active-low reset
//   req_valid/req_we/req_addr/req_wdata/req_ctrl : access request
//   flush                      : synchronous cancel of the current access
//   req_ready                  : request accepted this cycle (combinational)
//   stall                      : pipeline hold (combinational)
//   rsp_valid/rsp_err/rsp_rdata: registered completion pulse, error, data
//   dm_en/dm_mem_w/dm_addr/dm_wdata/dm_ctrl : registered controls to the
//                                byte-lane controller
//   dm_rdata                   : aligned, extended read data from it
module dm_access_seq #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ctrl,
  input  logic        flush,
  output logic        req_ready,
  output logic        stall,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        dm_en,
  output logic        dm_mem_w,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [2:0]  dm_ctrl,
  input  logic [31:0] dm_rdata
);

  // Width codes shared with the byte-lane controller. Byte codes
  // (dm_byte = 3, dm_byte_unsigned = 4) need no alignment check.
  localparam logic [2:0] DM_WORD              = 3'd0;
  localparam logic [2:0] DM_HALFWORD          = 3'd1;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'd2;

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        dm_en_q, dm_en_d;
  logic        dm_mem_w_q, dm_mem_w_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [2:0]  dm_ctrl_q, dm_ctrl_d;

  logic        misaligned;
  logic        capture;
  logic        addr_hold;

  assign req_ready = (state_q == IDLE) && !flush;
  assign stall     = (state_q == ACCESS) || (state_q == WAIT) ||
                     ((state_q == IDLE) && req_valid);

  assign misaligned =
      ((req_ctrl == DM_WORD) && (req_addr[1:0] != 2'b00)) ||
      (((req_ctrl == DM_HALFWORD) || (req_ctrl == DM_HALFWORD_UNSIGNED)) &&
       req_addr[0]);

  // Next-state and request latches
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          ctrl_d  = req_ctrl;
          state_d = misaligned ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_INIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          // Read data is valid this cycle; it becomes the response data.
          state_d = RESP;
          capture = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A cancel drops whatever is in flight, including a pending capture,
    // so no response is issued for it.
    if (flush && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      capture = 1'b0;
    end
  end

  // Registered outputs are derived from the state being entered so they
  // line up with that state in the following cycle.
  always_comb begin
    addr_hold   = (state_d == ACCESS) || (state_d == WAIT) || (state_d == RESP);
    rsp_valid_d = (state_d == RESP) || (state_d == ERR);
    rsp_err_d   = (state_d == ERR);
    rsp_rdata_d = rsp_rdata_q;
    if (state_d == ERR) begin
      rsp_rdata_d = 32'd0;
    end else if (state_d == RESP) begin
      rsp_rdata_d = capture ? dm_rdata : 32'd0;
    end
    dm_en_d    = (state_d == ACCESS);
    dm_mem_w_d = (state_d == ACCESS) && we_d;
    dm_addr_d  = addr_hold ? addr_d : 32'd0;
    dm_ctrl_d  = addr_hold ? ctrl_d : 3'd0;
    dm_wdata_d = (state_d == ACCESS) ? wdata_d : 32'd0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      ctrl_q      <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
      dm_en_q     <= 1'b0;
      dm_mem_w_q  <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_wdata_q  <= 32'd0;
      dm_ctrl_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      ctrl_q      <= ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      dm_en_q     <= dm_en_d;
      dm_mem_w_q  <= dm_mem_w_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      dm_ctrl_q   <= dm_ctrl_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dm_en     = dm_en_q;
  assign dm_mem_w  = dm_mem_w_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dm_ctrl   = dm_ctrl_q;

endmodule

// File: tb/tb_dm_access_seq.sv
// Testbench for dm_access_seq: two instances (RD_LAT=1 and RD_LAT=3) share
// one stimulus stream; a transaction-level model checks every cycle.
module tb_dm_access_seq;

  localparam logic [2:0] C_W  = 3'd0;
  localparam logic [2:0] C_H  = 3'd1;
  localparam logic [2:0] C_HU = 3'd2;
  localparam logic [2:0] C_B  = 3'd3;
  localparam logic [2:0] C_BU = 3'd4;

  localparam int K_LD  = 0;
  localparam int K_ST  = 1;
  localparam int K_MIS = 2;

  typedef struct packed {
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        dm_en;
    logic        dm_mem_w;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [2:0]  dm_ctrl;
  } outv_t;

  typedef struct {
    bit          active;
    int          t0;
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] held;
    logic [31:0] ld_data;
  } mstate_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  ctrl;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_err;
    int          exp_lat1;
    int          exp_lat3;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk, rstn;
  logic        req_valid, req_we, flush;
  logic [31:0] req_addr, req_wdata, dm_rdata;
  logic [2:0]  req_ctrl;

  logic        a_req_ready, a_stall, a_rsp_valid, a_rsp_err, a_dm_en, a_dm_mem_w;
  logic [31:0] a_rsp_rdata, a_dm_addr, a_dm_wdata;
  logic [2:0]  a_dm_ctrl;
  logic        b_req_ready, b_stall, b_rsp_valid, b_rsp_err, b_dm_en, b_dm_mem_w;
  logic [31:0] b_rsp_rdata, b_dm_addr, b_dm_wdata;
  logic [2:0]  b_dm_ctrl;

  outv_t out_a, out_b, snap_a, snap_b;
  assign out_a = {a_req_ready, a_stall, a_rsp_valid, a_rsp_err, a_rsp_rdata,
                  a_dm_en, a_dm_mem_w, a_dm_addr, a_dm_wdata, a_dm_ctrl};
  assign out_b = {b_req_ready, b_stall, b_rsp_valid, b_rsp_err, b_rsp_rdata,
                  b_dm_en, b_dm_mem_w, b_dm_addr, b_dm_wdata, b_dm_ctrl};

  dm_access_seq #(.RD_LAT(1)) dut_a (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
    .flush(flush), .req_ready(a_req_ready), .stall(a_stall),
    .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
    .dm_en(a_dm_en), .dm_mem_w(a_dm_mem_w), .dm_addr(a_dm_addr),
    .dm_wdata(a_dm_wdata), .dm_ctrl(a_dm_ctrl), .dm_rdata(dm_rdata)
  );

  dm_access_seq #(.RD_LAT(3)) dut_b (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ctrl(req_ctrl),
    .flush(flush), .req_ready(b_req_ready), .stall(b_stall),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
    .dm_en(b_dm_en), .dm_mem_w(b_dm_mem_w), .dm_addr(b_dm_addr),
    .dm_wdata(b_dm_wdata), .dm_ctrl(b_dm_ctrl), .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  int      cyc = 0;
  mstate_t ms[2];
  vec_t    tbl[8];

  task automatic chk_vec(input string name, input outv_t act, input outv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_hex(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic bit is_mis(input logic [2:0] c, input logic [31:0] a);
    return ((c == C_W) && (a % 4 != 0)) || (((c == C_H) || (c == C_HU)) && (a % 2 != 0));
  endfunction

  // Expected outputs for the current cycle from the transaction's age k,
  // then advance the model using the inputs of this cycle.
  task automatic model_step(input int d);
    outv_t e;
    int    lat;
    int    k;
    bit    last;
    lat = (d == 0) ? 1 : 3;
    k   = cyc - ms[d].t0;
    e   = '0;
    e.req_ready = !flush;
    e.stall     = req_valid;
    e.rsp_rdata = ms[d].held;
    if (!rstn) begin
      e.rsp_rdata = 32'd0;
    end else if (ms[d].active) begin
      e.req_ready = 1'b0;
      e.stall     = 1'b0;
      if (ms[d].kind == K_MIS) begin
        e.rsp_valid = 1'b1;
        e.rsp_err   = 1'b1;
        e.rsp_rdata = 32'd0;
      end else if (k == 1) begin
        e.stall    = 1'b1;
        e.dm_en    = 1'b1;
        e.dm_mem_w = (ms[d].kind == K_ST);
        e.dm_addr  = ms[d].addr;
        e.dm_wdata = ms[d].wdata;
        e.dm_ctrl  = ms[d].ctrl;
      end else begin
        e.dm_addr = ms[d].addr;
        e.dm_ctrl = ms[d].ctrl;
        if (ms[d].kind == K_ST) begin
          e.rsp_valid = 1'b1;
          e.rsp_rdata = 32'd0;
        end else if (k <= 1 + lat) begin
          e.stall = 1'b1;
        end else begin
          e.rsp_valid = 1'b1;
          e.rsp_rdata = ms[d].ld_data;
        end
      end
    end

    chk_vec((d == 0) ? "cycle_lat1" : "cycle_lat3", (d == 0) ? out_a : out_b, e);

    if (!rstn) begin
      ms[d].active = 1'b0;
      ms[d].held   = 32'd0;
    end else if (ms[d].active) begin
      if (e.rsp_valid) ms[d].held = e.rsp_rdata;
      if (ms[d].kind == K_LD && k == 1 + lat) ms[d].ld_data = dm_rdata;
      last = (ms[d].kind == K_MIS && k == 1) || (ms[d].kind == K_ST && k == 2) ||
             (ms[d].kind == K_LD && k == 2 + lat);
      if (last || flush) ms[d].active = 1'b0;
    end else if (req_valid && !flush) begin
      ms[d].active = 1'b1;
      ms[d].t0     = cyc;
      ms[d].kind   = is_mis(req_ctrl, req_addr) ? K_MIS : (req_we ? K_ST : K_LD);
      ms[d].addr   = req_addr;
      ms[d].wdata  = req_wdata;
      ms[d].ctrl   = req_ctrl;
    end
  endtask

  // One clock cycle: check at the falling edge, return just after rising.
  task automatic tick();
    @(negedge clk);
    model_step(0);
    model_step(1);
    snap_a = out_a;
    snap_b = out_b;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [2:0] ctrl,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         output int lat_a, output int lat_b,
                         output logic err_a, output logic err_b,
                         output logic [31:0] rd_a, output logic [31:0] rd_b,
                         output bit en_a, output bit en_b, output bit acc);
    req_we = we; req_addr = addr; req_ctrl = ctrl; req_wdata = wdata;
    dm_rdata = rdata; req_valid = 1'b1;
    tick();
    acc = snap_a.req_ready && snap_b.req_ready;
    req_valid = 1'b0;
    lat_a = -1; lat_b = -1; err_a = 1'b0; err_b = 1'b0;
    rd_a = 32'd0; rd_b = 32'd0; en_a = 1'b0; en_b = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (snap_a.rsp_valid && lat_a < 0) begin
        lat_a = n; err_a = snap_a.rsp_err; rd_a = snap_a.rsp_rdata;
      end
      if (snap_b.rsp_valid && lat_b < 0) begin
        lat_b = n; err_b = snap_b.rsp_err; rd_b = snap_b.rsp_rdata;
      end
      en_a = en_a | snap_a.dm_en;
      en_b = en_b | snap_b.dm_en;
    end
  endtask

  initial begin
    int          la, lb;
    logic        ea, eb;
    logic [31:0] ra, rb;
    bit          ena, enb, acc;
    int          cnt, acc2, na, nb;
    int          ca[2], cb[2];
    outv_t       zexp;

    tbl[0] = '{1'b0, 32'h10,  C_W,  32'h0,      32'hDEADBEEF, 1'b0, 3, 5, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 32'h13,  C_B,  32'hAB,     32'h55555555, 1'b0, 2, 2, 32'h0};
    tbl[2] = '{1'b0, 32'h21,  C_H,  32'h0,      32'h11111111, 1'b1, 1, 1, 32'h0};
    tbl[3] = '{1'b0, 32'h22,  C_W,  32'h0,      32'h22222222, 1'b1, 1, 1, 32'h0};
    tbl[4] = '{1'b0, 32'h42,  C_HU, 32'h0,      32'h0000BEEF, 1'b0, 3, 5, 32'h0000BEEF};
    tbl[5] = '{1'b1, 32'h41,  C_W,  32'h1234,   32'h33333333, 1'b1, 1, 1, 32'h0};
    tbl[6] = '{1'b0, 32'h7,   C_BU, 32'h0,      32'h00000080, 1'b0, 3, 5, 32'h00000080};
    tbl[7] = '{1'b1, 32'h102, C_H,  32'h5678,   32'h44444444, 1'b0, 2, 2, 32'h0};

    for (int d = 0; d < 2; d++) begin
      ms[d].active = 1'b0; ms[d].t0 = 0; ms[d].kind = 0; ms[d].addr = 0;
      ms[d].wdata = 0; ms[d].ctrl = 0; ms[d].held = 0; ms[d].ld_data = 0;
    end

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; flush = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_ctrl = 3'd0; dm_rdata = 32'd0;
    #2;
    tick();
    tick();
    zexp = '0;
    zexp.req_ready = 1'b1;
    chk_vec("reset_state_lat1", snap_a, zexp);
    chk_vec("reset_state_lat3", snap_b, zexp);
    rstn = 1'b1;
    tick();
    chk_int("ready_after_reset", int'(snap_a.req_ready && snap_b.req_ready), 1);

    // Directed single requests
    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].we, tbl[i].addr, tbl[i].ctrl, tbl[i].wdata, tbl[i].rdata,
              la, lb, ea, eb, ra, rb, ena, enb, acc);
      $display("vec %0d: addr=%h ctrl=%0d we=%0b lat1=%0d lat3=%0d err=%0b/%0b rdata=%h/%h",
               i, tbl[i].addr, tbl[i].ctrl, tbl[i].we, la, lb, ea, eb, ra, rb);
      chk_int("vec_accept", int'(acc), 1);
      chk_int("vec_rsp_cycle_lat1", la, tbl[i].exp_lat1);
      chk_int("vec_rsp_cycle_lat3", lb, tbl[i].exp_lat3);
      chk_int("vec_err_lat1", int'(ea), int'(tbl[i].exp_err));
      chk_int("vec_err_lat3", int'(eb), int'(tbl[i].exp_err));
      chk_hex("vec_rdata_lat1", ra, tbl[i].exp_rdata);
      chk_hex("vec_rdata_lat3", rb, tbl[i].exp_rdata);
      chk_int("vec_dm_en_seen", int'(ena && enb), int'(!tbl[i].exp_err));
    end

    // Flush in the first WAIT cycle cancels the load
    req_we = 1'b0; req_addr = 32'h80; req_ctrl = C_W; dm_rdata = 32'hA5A5A5A5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk_int("flush_ready_after", int'(snap_a.req_ready && snap_b.req_ready), 1);
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      cnt += int'(snap_a.rsp_valid) + int'(snap_b.rsp_valid);
    end
    chk_int("flush_no_rsp", cnt, 0);
    $display("flush in WAIT: responses seen=%0d", cnt);

    // Asynchronous reset during WAIT
    req_addr = 32'h90; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    #1 rstn = 1'b0;
    #1;
    chk_vec("async_reset_lat1", out_a, zexp);
    chk_vec("async_reset_lat3", out_b, zexp);
    tick();
    rstn = 1'b1;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      cnt += int'(snap_a.rsp_valid) + int'(snap_b.rsp_valid);
    end
    chk_int("reset_no_rsp", cnt, 0);
    run_req(1'b0, 32'hA0, C_W, 32'h0, 32'h12345678, la, lb, ea, eb, ra, rb, ena, enb, acc);
    $display("load after reset: lat1=%0d lat3=%0d rdata=%h/%h", la, lb, ra, rb);
    chk_int("post_reset_lat1", la, 3);
    chk_int("post_reset_lat3", lb, 5);
    chk_hex("post_reset_rdata", rb, 32'h12345678);

    // Store then load with req_valid held
    req_we = 1'b1; req_addr = 32'h200; req_ctrl = C_W; req_wdata = 32'hCAFEF00D;
    dm_rdata = 32'h0BADF00D; req_valid = 1'b1;
    tick();
    chk_int("b2b_first_accept", int'(snap_a.req_ready), 1);
    req_we = 1'b0; req_addr = 32'h204;
    acc2 = -1; na = 0; nb = 0; ca = '{-1, -1}; cb = '{-1, -1};
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (snap_a.req_ready && req_valid && acc2 < 0) begin
        acc2 = n;
        req_valid = 1'b0;
      end
      if (snap_a.rsp_valid && na < 2) begin ca[na] = n; na++; end
      if (snap_b.rsp_valid && nb < 2) begin cb[nb] = n; nb++; end
    end
    $display("back-to-back: second accept=%0d rsp lat1=%0d,%0d lat3=%0d,%0d",
             acc2, ca[0], ca[1], cb[0], cb[1]);
    chk_int("b2b_second_accept", acc2, 3);
    chk_int("b2b_store_rsp_lat1", ca[0], 2);
    chk_int("b2b_load_rsp_lat1", ca[1], 6);
    chk_int("b2b_load_rsp_lat3", cb[1], 8);
    chk_hex("b2b_load_rdata", snap_b.rsp_rdata, 32'h0BADF00D);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_we    = 1'($urandom_range(0, 1));
      req_ctrl  = 3'($urandom_range(0, 4));
      req_addr  = $urandom;
      if ($urandom_range(0, 3) != 0) req_addr[1:0] = 2'b00;
      req_wdata = $urandom;
      dm_rdata  = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    req_valid = 1'b0;
    flush = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    $display("random phase done at cycle %0d", cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
